// File: rtl/board_pkg.sv
// Shared board geometry, cell/row types and update-sequence states for the
// board colour store.
package board_pkg;

    localparam int BOARD_W   = 10;
    localparam int BOARD_H   = 20;
    localparam int COLOR_W   = 16;
    localparam int COORD_W   = 7;
    localparam int COL_IDX_W = $clog2(BOARD_W);
    localparam int ROW_IDX_W = $clog2(BOARD_H);

    typedef logic [COLOR_W-1:0] color_t;
    typedef color_t [BOARD_W-1:0] row_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ERASE,
        DRAW,
        DONE
    } state_t;

    // True when (x,y) addresses a real cell on the board.
    function automatic logic cell_in_range(input logic [COORD_W-1:0] x,
                                           input logic [COORD_W-1:0] y);
        return (x < COORD_W'(BOARD_W)) && (y < COORD_W'(BOARD_H));
    endfunction

endpackage

// File: rtl/board_color_store_frame_edge_sync.sv
// Brings the game-logic frame tick into the Clk domain and turns each
// rising edge into a single-cycle pulse.
module frame_edge_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic async_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic edge_q;

    // Two-flop synchroniser followed by a delay stage used for edge detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~edge_q;

endmodule

// File: rtl/board_color_store.sv
// Owns the 10x20 board colour image: each frame tick it optionally shifts
// cleared rows down, erases the previous piece cells and draws the current
// ones, while serving a registered read port to the pixel renderer.
module board_color_store
    import board_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_clk,
    input  logic [4*COORD_W-1:0]   blockXPos,
    input  logic [4*COORD_W-1:0]   blockYPos,
    input  logic [4*COORD_W-1:0]   blockXPrev,
    input  logic [4*COORD_W-1:0]   blockYPrev,
    input  logic [COLOR_W-1:0]     blockColor,
    input  logic                   Clear_row,
    input  logic [3:0]             Num_rows_to_clear,
    input  logic [COORD_W-1:0]     Row_to_clear,
    input  logic [COORD_W-1:0]     rd_x,
    input  logic [COORD_W-1:0]     rd_y,
    output logic [COLOR_W-1:0]     rd_color,
    output logic                   busy,
    output logic                   update_done,
    output logic                   overrun
);

    logic fe;

    state_t               state_q;
    row_t                 board_q [BOARD_H];
    logic [4*COORD_W-1:0] xpos_q;
    logic [4*COORD_W-1:0] ypos_q;
    logic [4*COORD_W-1:0] xprev_q;
    logic [4*COORD_W-1:0] yprev_q;
    color_t               color_q;
    logic [3:0]           num_q;
    logic [COORD_W-1:0]   row_cnt_q;
    logic [1:0]           idx_q;
    logic                 busy_q;
    logic                 update_done_q;
    logic                 overrun_q;
    color_t               rd_color_q;

    logic [COORD_W-1:0]   selX;
    logic [COORD_W-1:0]   selY;
    logic                 selValid;
    logic                 selNoPrev;
    logic [COORD_W-1:0]   srcRow;
    logic                 copyFromSrc;

    frame_edge_sync u_sync (
        .Clk     (Clk),
        .Reset   (Reset),
        .async_i (frame_clk),
        .pulse_o (fe)
    );

    // Pick the cell addressed this cycle (previous list while erasing,
    // current list while drawing) and the source row for a row-clear copy.
    always_comb begin
        selX = '0;
        selY = '0;
        if (state_q == ERASE) begin
            selX = xprev_q[idx_q*COORD_W +: COORD_W];
            selY = yprev_q[idx_q*COORD_W +: COORD_W];
        end else begin
            selX = xpos_q[idx_q*COORD_W +: COORD_W];
            selY = ypos_q[idx_q*COORD_W +: COORD_W];
        end
        selValid    = cell_in_range(selX, selY);
        selNoPrev   = (selX == '0) && (selY == '0);
        copyFromSrc = row_cnt_q >= COORD_W'(num_q);
        srcRow      = row_cnt_q - COORD_W'(num_q);
    end

    // Update sequencer: captures a frame, walks CLEAR/ERASE/DRAW/DONE and
    // applies the resulting writes to the board image.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            board_q       <= '{default: '0};
            xpos_q        <= '0;
            ypos_q        <= '0;
            xprev_q       <= '0;
            yprev_q       <= '0;
            color_q       <= '0;
            num_q         <= '0;
            row_cnt_q     <= '0;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            update_done_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            update_done_q <= 1'b0;
            overrun_q     <= fe && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (fe) begin
                        xpos_q    <= blockXPos;
                        ypos_q    <= blockYPos;
                        xprev_q   <= blockXPrev;
                        yprev_q   <= blockYPrev;
                        color_q   <= blockColor;
                        num_q     <= Num_rows_to_clear;
                        row_cnt_q <= Row_to_clear;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        if (Clear_row && (Num_rows_to_clear != '0) &&
                            (Row_to_clear < COORD_W'(BOARD_H))) begin
                            state_q <= CLEAR;
                        end else begin
                            state_q <= ERASE;
                        end
                    end
                end
                CLEAR: begin
                    if (copyFromSrc) begin
                        board_q[row_cnt_q[ROW_IDX_W-1:0]] <= board_q[srcRow[ROW_IDX_W-1:0]];
                    end else begin
                        board_q[row_cnt_q[ROW_IDX_W-1:0]] <= '0;
                    end
                    if (row_cnt_q == '0) begin
                        state_q <= ERASE;
                    end else begin
                        row_cnt_q <= row_cnt_q - 1'b1;
                    end
                end
                ERASE: begin
                    if (selValid && !selNoPrev) begin
                        board_q[selY[ROW_IDX_W-1:0]][selX[COL_IDX_W-1:0]] <= '0;
                    end
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == 2'd3) begin
                        state_q <= DRAW;
                    end
                end
                DRAW: begin
                    if (selValid) begin
                        board_q[selY[ROW_IDX_W-1:0]][selX[COL_IDX_W-1:0]] <= color_q;
                    end
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == 2'd3) begin
                        state_q       <= DONE;
                        update_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Registered read port; sees the board as it was before this cycle's write.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_color_q <= '0;
        end else if (cell_in_range(rd_x, rd_y)) begin
            rd_color_q <= board_q[rd_y[ROW_IDX_W-1:0]][rd_x[COL_IDX_W-1:0]];
        end else begin
            rd_color_q <= '0;
        end
    end

    assign rd_color    = rd_color_q;
    assign busy        = busy_q;
    assign update_done = update_done_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/board_color_store.md
Name: board_color_store

Overview:
- Consumer end of the game-logic piece interface: owns the 10x20 board colour image and applies what the game logic reports.
- Each frame it applies the game logic's falling-piece positions (previous and current), its colour, and row-clear commands to that image.
- Serves a 1-cycle-latency read port to the VGA colour mapper.
- Sits between game logic (frame_clk domain outputs) and the pixel renderer; runs entirely on Clk.

Parameters:
BOARD_W, 10, cells per row (columns 0..BOARD_W-1)
BOARD_H, 20, rows (0 = top)
COLOR_W, 16, bits per cell colour; 0 = empty

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  game-logic frame tick, asynchronous to Clk
blockXPos  in  7 x4  current piece cell columns
blockYPos  in  7 x4  current piece cell rows
blockXPrev  in  7 x4  previous piece cell columns
blockYPrev  in  7 x4  previous piece cell rows
blockColor  in  COLOR_W  current piece colour
Clear_row  in  1  level, held one whole frame: clear request
Num_rows_to_clear  in  4  rows to remove (0 = none)
Row_to_clear  in  7  lowest (largest Y) row to remove
rd_x  in  7  read column
rd_y  in  7  read row
rd_color  out  COLOR_W  colour at (rd_x,rd_y), registered
busy  out  1  update sequence in progress
update_done  out  1  one-cycle pulse when a sequence completes
overrun  out  1  one-cycle pulse when a frame edge arrives while busy

Behaviour:
- Reset (async, active-high):
  - all cells = 0; rd_color = 0; busy/update_done/overrun = 0.
  - Synchroniser and edge register cleared; FSM -> IDLE.
- frame_clk passes through a 2-flop synchroniser plus edge register; a rising edge yields a 1-cycle fe pulse.
- IDLE, fe=1 (cycle C0):
  - Capture all piece inputs, blockColor, Clear_row, Num_rows_to_clear and Row_to_clear into shadow registers.
  - Next state: CLEAR if the captured Clear_row=1 and Num_rows_to_clear!=0 and Row_to_clear<BOARD_H; otherwise ERASE.
- CLEAR:
  - Row counter r starts at Row_to_clear and decrements by 1 each cycle.
  - Each cycle, whole-row copy: row[r] <= row[r-N] if r>=N, else all zeros (N = Num_rows_to_clear, unclamped).
  - Descending order means each source row is still unmodified when read.
  - After r=0 -> ERASE. Length = Row_to_clear+1 cycles.
- ERASE:
  - Index i=0..3, one cell per cycle; cell (Xprev[i],Yprev[i]) <= 0.
  - An entry with Xprev=0 and Yprev=0 is "no previous cell" and is skipped (cycle still consumed).
  - Then -> DRAW.
- DRAW: i=0..3, one cell per cycle; cell (XPos[i],YPos[i]) <= captured colour. Then -> DONE.
- DONE: update_done=1 for one cycle -> IDLE.
- busy=1 in CLEAR, ERASE, DRAW and DONE; 0 in IDLE.
- No-clear timing: ERASE C1..C4, DRAW C5..C8, update_done at C9.
- Bounds: any write with X>=BOARD_W or Y>=BOARD_H is dropped silently.
- Overlap: a cell in both the prev and current lists ends up with the new colour, because DRAW follows ERASE.
- fe while busy: the frame is dropped and overrun pulses for 1 cycle. The sequence in progress is unaffected.
- Read port:
  - rd_color <= cell(rd_x,rd_y) every cycle; 0 if out of range.
  - Reads see the array state before that cycle's write; no stall on writes.
- Storage: flops, BOARD_H rows x (BOARD_W*COLOR_W) bits, so a whole row copies in one cycle.
- Reset mid-sequence: immediate return to IDLE with a cleared board; no partial writes after Reset deasserts.

Decomposition:
- Package board_pkg:
  - BOARD_W, BOARD_H, COLOR_W, COORD_W=7.
  - typedef color_t, typedef row_t (BOARD_W colours).
  - enum state_t {IDLE, CLEAR, ERASE, DRAW, DONE}.
- One sub-module, frame_edge_sync: 2-flop synchroniser plus rising-edge pulse, with async active-high Reset.

Test Plan:
- Reset, then 3 frame edges with no piece change, rd sweep of all cells -> all 0.
- Draw with no clear: prev all (0,0), cur (4,0),(4,1),(5,1),(5,2), colour 16'h0f00, one frame.
  - update_done 9 Clk after the synchronised edge.
  - Those 4 cells read 16'h0f00; (0,0) reads 0.
- Move: next frame prev = those cells, cur shifted +1 in Y -> old-only cells (4,0),(5,1)... read 0; overlapping and new cells read 16'h0f00.
- Clear 1 row: row 19 full of 16'h05f0, row 18 cell (3,18)=16'h00a8, Clear_row=1, N=1, Row_to_clear=19.
  - Result: (3,19)=16'h00a8, row 18 all 0, row 0 all 0.
  - busy lasts 20+8+1 cycles.
- Clear 2 rows, Row_to_clear=1 -> rows 0..1 zeroed, rows 2..19 unchanged.
- Frame edge injected during ERASE -> overrun pulses once, no second sequence.
- Reset asserted mid-CLEAR -> board all 0, busy=0 immediately.
- Out-of-range cell (10,5) in the cur list -> no write; reading (10,5) returns 0.
